// File: rtl/mm_job_arbiter.sv
// Two-client job arbiter for a shared matrix engine: round-robin grant,
// stream mux into the engine, tagged result bus and a per-job watchdog.
module mm_job_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  in_data0,
  input  logic [7:0]  in_data1,
  input  logic        col_end0,
  input  logic        col_end1,
  input  logic        row_end0,
  input  logic        row_end1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        mm_rst,
  output logic [7:0]  mm_in_data,
  output logic        mm_col_end,
  output logic        mm_row_end,
  input  logic [19:0] mm_out_data,
  input  logic        mm_valid,
  input  logic        mm_is_legal,
  input  logic        mm_change_row,
  input  logic        mm_busy,
  output logic [19:0] res_data,
  output logic        res_valid,
  output logic        res_legal,
  output logic        res_change_row,
  output logic        res_owner,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1
);

  typedef enum logic [2:0] {IDLE, GRANT, LOAD, RUN, RELEASE} state_t;

  state_t     state, state_next;
  logic       owner, owner_next;
  logic       aborted, aborted_next;
  logic       last_owner;
  logic [6:0] wdog;
  logic       row_seen;
  logic       busy_seen;
  logic       sel_row_end;
  logic       timeout;

  assign sel_row_end = owner ? row_end1 : row_end0;
  // Abort on the edge where the watchdog would reach 127.
  assign timeout     = (wdog == 7'd126);

  always_comb begin
    state_next   = state;
    owner_next   = owner;
    aborted_next = aborted;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_next   = GRANT;
          owner_next   = (req0 && req1) ? ~last_owner : req1;
          aborted_next = 1'b0;
        end
      end
      GRANT: state_next = LOAD;
      LOAD: begin
        if (timeout) begin
          state_next   = RELEASE;
          aborted_next = 1'b1;
        end else if (sel_row_end && row_seen) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (timeout) begin
          state_next   = RELEASE;
          aborted_next = 1'b1;
        end else if (busy_seen && !mm_busy) begin
          state_next = RELEASE;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      aborted    <= 1'b0;
      last_owner <= 1'b1;
      wdog       <= '0;
      row_seen   <= 1'b0;
      busy_seen  <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      mm_rst     <= 1'b1;
    end else begin
      state   <= state_next;
      owner   <= owner_next;
      aborted <= aborted_next;
      // Grant and engine reset are decoded from the next state so they
      // change on the same edge as the state register.
      gnt0    <= (state_next == GRANT || state_next == LOAD) && !owner_next;
      gnt1    <= (state_next == GRANT || state_next == LOAD) && owner_next;
      mm_rst  <= !(state_next == LOAD || state_next == RUN);

      if (state == IDLE && state_next == GRANT)
        wdog <= '0;
      else if (state == LOAD || state == RUN)
        wdog <= wdog + 7'd1;

      if (state == LOAD && sel_row_end)
        row_seen <= 1'b1;
      if (state == RUN && mm_busy)
        busy_seen <= 1'b1;

      if (state == RELEASE) begin
        last_owner <= owner;
        wdog       <= '0;
        row_seen   <= 1'b0;
        busy_seen  <= 1'b0;
      end
    end
  end

  always_comb begin
    mm_in_data = '0;
    mm_col_end = 1'b0;
    mm_row_end = 1'b0;
    if (state == LOAD) begin
      mm_in_data = owner ? in_data1 : in_data0;
      mm_col_end = owner ? col_end1 : col_end0;
      mm_row_end = sel_row_end;
    end
  end

  always_comb begin
    res_data       = '0;
    res_valid      = 1'b0;
    res_legal      = 1'b0;
    res_change_row = 1'b0;
    if (state == RUN) begin
      res_data       = mm_out_data;
      res_valid      = mm_valid;
      res_legal      = mm_is_legal;
      res_change_row = mm_change_row;
    end
  end

  assign res_owner = owner;
  assign done0     = (state == RELEASE) && !aborted && !owner;
  assign done1     = (state == RELEASE) && !aborted && owner;
  assign err0      = (state == RELEASE) && aborted && !owner;
  assign err1      = (state == RELEASE) && aborted && owner;

endmodule

// File: tb/tb_mm_job_arbiter.sv
// Directed self-checking bench for mm_job_arbiter; the bench plays both
// clients and the matrix engine with hand-computed results.
module tb_mm_job_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [7:0]  in_data0, in_data1;
  logic        col_end0, col_end1, row_end0, row_end1;
  logic        gnt0, gnt1, mm_rst;
  logic [7:0]  mm_in_data;
  logic        mm_col_end, mm_row_end;
  logic [19:0] mm_out_data;
  logic        mm_valid, mm_is_legal, mm_change_row, mm_busy;
  logic [19:0] res_data;
  logic        res_valid, res_legal, res_change_row, res_owner;
  logic        done0, done1, err0, err1;

  int checks   = 0;
  int failures = 0;

  mm_job_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .in_data0(in_data0), .in_data1(in_data1),
    .col_end0(col_end0), .col_end1(col_end1),
    .row_end0(row_end0), .row_end1(row_end1),
    .gnt0(gnt0), .gnt1(gnt1), .mm_rst(mm_rst),
    .mm_in_data(mm_in_data), .mm_col_end(mm_col_end), .mm_row_end(mm_row_end),
    .mm_out_data(mm_out_data), .mm_valid(mm_valid), .mm_is_legal(mm_is_legal),
    .mm_change_row(mm_change_row), .mm_busy(mm_busy),
    .res_data(res_data), .res_valid(res_valid), .res_legal(res_legal),
    .res_change_row(res_change_row), .res_owner(res_owner),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    chk1("gnt_onehot", gnt0 & gnt1, 1'b0);
  endtask

  task automatic wait_grant(input logic c);
    for (int i = 0; i < 4; i++) begin
      tick;
      if (gnt0 || gnt1) break;
    end
    chk1("grant_owner", c ? gnt1 : gnt0, 1'b1);
    chk1("grant_other", c ? gnt0 : gnt1, 1'b0);
    chk1("grant_res_owner", res_owner, c);
    chk1("grant_mm_rst", mm_rst, 1'b1);
  endtask

  // Owner drives the element; the other client drives the complement so a
  // wrong mux select is visible.
  task automatic send(input logic c, input logic [7:0] d, input logic ce, input logic re);
    if (c) begin
      in_data1 = d;  col_end1 = ce;  row_end1 = re;
      in_data0 = ~d; col_end0 = ~ce; row_end0 = ~re;
    end else begin
      in_data0 = d;  col_end0 = ce;  row_end0 = re;
      in_data1 = ~d; col_end1 = ~ce; row_end1 = ~re;
    end
    #1;
    chkw("load_in_data", {12'b0, mm_in_data}, {12'b0, d});
    chk1("load_col_end", mm_col_end, ce);
    chk1("load_row_end", mm_row_end, re);
    chk1("load_mm_rst", mm_rst, 1'b0);
    chk1("load_gnt", c ? gnt1 : gnt0, 1'b1);
    tick;
  endtask

  task automatic send_matrix(input logic c, input int rows, input int cols, input logic [47:0] m);
    for (int i = 0; i < rows * cols; i++)
      send(c, m[47-8*i -: 8], (i % cols) == cols - 1, i == rows * cols - 1);
  endtask

  // Called in the GRANT cycle; returns in the IDLE cycle after RELEASE.
  task automatic run_job(input logic c,
                         input logic [47:0] a, input int ar, input int ac,
                         input logic [47:0] b, input int br, input int bc,
                         input int n, input logic [79:0] res,
                         input logic legal, input logic [3:0] chg);
    tick;
    send_matrix(c, ar, ac, a);
    send_matrix(c, br, bc, b);
    in_data0 = 8'hAA; in_data1 = 8'hAA;
    col_end0 = 1'b1; col_end1 = 1'b1; row_end0 = 1'b1; row_end1 = 1'b1;
    #1;
    chkw("run_in_data_zero", {12'b0, mm_in_data}, 20'd0);
    chk1("run_col_end_zero", mm_col_end, 1'b0);
    chk1("run_row_end_zero", mm_row_end, 1'b0);
    chk1("run_gnt_low", c ? gnt1 : gnt0, 1'b0);
    chk1("run_mm_rst_low", mm_rst, 1'b0);
    in_data0 = '0; in_data1 = '0;
    col_end0 = 1'b0; col_end1 = 1'b0; row_end0 = 1'b0; row_end1 = 1'b0;
    mm_busy = 1'b1;
    #1;
    chk1("run_idle_valid", res_valid, 1'b0);
    tick;
    for (int i = 0; i < n; i++) begin
      mm_valid = 1'b1;
      mm_out_data = res[79-20*i -: 20];
      mm_is_legal = legal;
      mm_change_row = chg[i];
      #1;
      chk1("res_valid", res_valid, 1'b1);
      chkw("res_data", res_data, res[79-20*i -: 20]);
      chk1("res_legal", res_legal, legal);
      chk1("res_change_row", res_change_row, chg[i]);
      chk1("res_owner", res_owner, c);
      chk1("no_done_in_run", c ? done1 : done0, 1'b0);
      tick;
    end
    mm_valid = 1'b0; mm_out_data = '0; mm_is_legal = 1'b0; mm_change_row = 1'b0;
    mm_busy = 1'b0;
    tick;
    mm_valid = 1'b1; mm_is_legal = 1'b1; mm_change_row = 1'b1; mm_out_data = 20'h12345;
    #1;
    chk1("release_done", c ? done1 : done0, 1'b1);
    chk1("release_other_done", c ? done0 : done1, 1'b0);
    chk1("release_err0", err0, 1'b0);
    chk1("release_err1", err1, 1'b0);
    chk1("release_mm_rst", mm_rst, 1'b1);
    chk1("release_gnt", gnt0 | gnt1, 1'b0);
    chk1("release_res_valid", res_valid, 1'b0);
    chk1("release_res_legal", res_legal, 1'b0);
    chk1("release_res_chg", res_change_row, 1'b0);
    chkw("release_res_data", res_data, 20'd0);
    mm_valid = 1'b0; mm_is_legal = 1'b0; mm_change_row = 1'b0; mm_out_data = '0;
    tick;
    chk1("idle_done_clear", c ? done1 : done0, 1'b0);
  endtask

  logic [47:0] a1, b1, a2, b2, a3, b3;
  logic [79:0] r1, r2, r3;

  initial begin
    a1 = {8'd1, 8'd2, 8'd3, 8'd4, 16'd0};
    b1 = {8'd5, 8'd6, 8'd7, 8'd8, 16'd0};
    r1 = {20'd19, 20'd22, 20'd43, 20'd50};
    a2 = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    b2 = {8'd1, 8'd0, 8'd0, 8'd1, 16'd0};
    r2 = '0;
    a3 = {8'd2, 8'd0, 8'd1, 8'd3, 16'd0};
    b3 = {8'd1, 8'd1, 8'd0, 8'd2, 16'd0};
    r3 = {20'd2, 20'd2, 20'd1, 20'd7};

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    in_data0 = '0; in_data1 = '0;
    col_end0 = 1'b0; col_end1 = 1'b0; row_end0 = 1'b0; row_end1 = 1'b0;
    mm_out_data = '0; mm_valid = 1'b0; mm_is_legal = 1'b0;
    mm_change_row = 1'b0; mm_busy = 1'b0;
    tick; tick;
    chk1("rst_gnt0", gnt0, 1'b0);
    chk1("rst_gnt1", gnt1, 1'b0);
    chk1("rst_mm_rst", mm_rst, 1'b1);
    chk1("rst_done0", done0, 1'b0);
    chk1("rst_err1", err1, 1'b0);
    chk1("rst_res_owner", res_owner, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chkw("rst_mm_in_data", {12'b0, mm_in_data}, 20'd0);

    // Illegal job from client 1: 2x3 times 2x2.
    rst = 1'b0;
    req1 = 1'b1;
    wait_grant(1'b1);
    req1 = 1'b0;
    run_job(1'b1, a2, 2, 3, b2, 2, 2, 1, r2, 1'b0, 4'b0000);

    // Legal job from client 0.
    req0 = 1'b1;
    wait_grant(1'b0);
    req0 = 1'b0;
    run_job(1'b0, a1, 2, 2, b1, 2, 2, 4, r1, 1'b1, 4'b0100);

    // Contention right after reset; last owner was 0, reset must restore 1.
    rst = 1'b1;
    tick; tick;
    chk1("rst2_mm_rst", mm_rst, 1'b1);
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    wait_grant(1'b0);
    req0 = 1'b0;
    run_job(1'b0, a1, 2, 2, b1, 2, 2, 4, r1, 1'b1, 4'b0100);
    wait_grant(1'b1);
    req1 = 1'b0;
    run_job(1'b1, a3, 2, 2, b3, 2, 2, 4, r3, 1'b1, 4'b0100);

    // Timeout: client 0 streams data but never a row_end.
    req0 = 1'b1;
    wait_grant(1'b0);
    req0 = 1'b0;
    tick;
    chk1("to_first_load_mm_rst", mm_rst, 1'b0);
    in_data0 = 8'd9; col_end0 = 1'b1;
    for (int k = 1; k <= 126; k++) tick;
    chk1("to_err0_before", err0, 1'b0);
    chk1("to_mm_rst_before", mm_rst, 1'b0);
    tick;
    chk1("to_err0", err0, 1'b1);
    chk1("to_done0", done0, 1'b0);
    chk1("to_mm_rst_release", mm_rst, 1'b1);
    chk1("to_gnt0", gnt0, 1'b0);
    in_data0 = '0; col_end0 = 1'b0;
    tick;
    chk1("to_err0_clear", err0, 1'b0);
    req1 = 1'b1;
    wait_grant(1'b1);
    req1 = 1'b0;
    run_job(1'b1, a3, 2, 2, b3, 2, 2, 4, r3, 1'b1, 4'b0100);

    // Reset while client 0 is in RUN.
    req0 = 1'b1;
    wait_grant(1'b0);
    req0 = 1'b0;
    tick;
    send_matrix(1'b0, 2, 2, a1);
    send_matrix(1'b0, 2, 2, b1);
    mm_busy = 1'b1;
    tick;
    mm_valid = 1'b1; mm_is_legal = 1'b1; mm_out_data = 20'd19;
    #1;
    chkw("midrun_res_data", res_data, 20'd19);
    rst = 1'b1;
    tick;
    chk1("midrun_gnt0", gnt0, 1'b0);
    chk1("midrun_mm_rst", mm_rst, 1'b1);
    chk1("midrun_done0", done0, 1'b0);
    chk1("midrun_err0", err0, 1'b0);
    chk1("midrun_res_valid", res_valid, 1'b0);
    rst = 1'b0;
    mm_valid = 1'b0; mm_is_legal = 1'b0; mm_out_data = '0; mm_busy = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    wait_grant(1'b0);
    req0 = 1'b0; req1 = 1'b0;
    run_job(1'b0, a1, 2, 2, b1, 2, 2, 4, r1, 1'b1, 4'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mm_job_arbiter.md
MM_JOB_ARBITER -- requirements
Module: mm_job_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req0, req1  input  1 each  job request from client 0 and client 1; level, sampled only in IDLE.
REQ-005 in_data0, in_data1  input  8 each  client matrix element stream.
REQ-006 col_end0, col_end1, row_end0, row_end1  input  1 each  client stream markers, same meaning as at the matrix engine.
REQ-007 gnt0, gnt1  output  1 each  registered grant, one-hot or zero.
REQ-008 mm_rst  output  1  registered reset to the matrix engine.
REQ-009 mm_in_data  output  8; mm_col_end, mm_row_end  output  1  muxed stream to the engine.
REQ-010 mm_out_data  input  20; mm_valid, mm_is_legal, mm_change_row, mm_busy  input  1  engine results and status.
REQ-011 res_data  output  20; res_valid, res_legal, res_change_row, res_owner  output  1  shared result bus tagged with the owner.
REQ-012 done0, done1  output  1 each  one-cycle job-complete pulse per client.
REQ-013 err0, err1  output  1 each  one-cycle timeout-abort pulse per client.

Function
REQ-014 The FSM SHALL have the states IDLE, GRANT, LOAD, RUN and RELEASE.
REQ-015 In IDLE, if any req is high, the FSM SHALL select the owner and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: with one requester it wins; with both, the client other than last_owner wins; last_owner resets to 1, so client 0 wins first.
REQ-017 GRANT SHALL last one cycle and lead to LOAD; gnt of the owner SHALL be high in GRANT and LOAD, and low in all other states.
REQ-018 mm_rst SHALL be high in IDLE, GRANT and RELEASE and during rst; it SHALL be low in LOAD and RUN, taking effect on the same edge the FSM enters LOAD.
REQ-019 The client SHALL present its first element in the first LOAD cycle and stream contiguously (matrix A then matrix B); the block SHALL combinationally forward the owner's in_data, col_end and row_end to the engine in LOAD.
REQ-020 Outside LOAD, mm_in_data, mm_col_end and mm_row_end SHALL be 0.
REQ-021 The block SHALL count owner row_end pulses in LOAD; on the second pulse it SHALL go to RUN on the next edge.
REQ-022 In RUN, res_valid SHALL equal mm_valid, and res_data, res_legal and res_change_row SHALL pass through combinationally; res_owner SHALL equal the owner bit in all states.
REQ-023 Outside RUN, res_valid, res_legal and res_change_row SHALL be 0; res_data SHALL be 0.
REQ-024 RUN SHALL end when mm_busy is sampled high and later sampled low (falling edge of busy); the FSM SHALL then go to RELEASE.
REQ-025 RELEASE SHALL last one cycle: pulse done of the owner, set last_owner to the owner, clear the counters, then go to IDLE.
REQ-026 A 7-bit watchdog SHALL clear on entry to GRANT and increment every cycle in LOAD and RUN.
REQ-027 If the watchdog reaches 127, the block SHALL abort: go to RELEASE with the owner's err pulsed instead of done; mm_rst asserts there, which clears the engine.
REQ-028 A req that stays high after done or err SHALL be re-arbitrated normally in IDLE; a req dropped while granted SHALL NOT abort the job.
REQ-029 An illegal job (the engine asserts valid with is_legal low) SHALL be forwarded as a normal result and completes on the busy fall like any other job.

Reset
REQ-030 On rst, the block SHALL set state IDLE, last_owner 1, and clear the watchdog and row_end counter.
REQ-031 On rst, all outputs SHALL be 0 except mm_rst, which SHALL be 1.
REQ-032 rst asserted mid-job SHALL abandon the job without a done or err pulse.

Verification
REQ-033 Legal job: req0, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> res_valid pulses with res_data 19, 22, 43, 50, res_owner 0, res_legal 1; then done0 pulses once.
REQ-034 Illegal job: req1, A is 2x3 and B is 2x2 -> one res_valid with res_legal 0 and res_owner 1; then done1 pulses; no err.
REQ-035 Contention: req0 and req1 high in the same IDLE cycle after reset -> client 0 is served first, then client 1, with both result sets correct and never both gnt high.
REQ-036 Timeout: req0 granted and the client never sends row_end -> err0 pulses 127 cycles after GRANT; mm_rst is high in RELEASE; the next req1 job is correct.
REQ-037 Reset mid-RUN: assert rst during RUN of a client 0 job -> next cycle gnt0 is 0 and mm_rst is 1 with no done0 or err0; a fresh job is correct and client 0 wins first.
